// File: rtl/calc_check_ctrl.sv
// calc_check_ctrl: operand confirm pulse, matrix dimension checker and error countdown.
// Optional macro CALC_CHECK_RETRY_EN lets btn_c abort the error countdown for an early retry.
module calc_check_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int ERR_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] current_state,
  input  logic       btn_c,
  input  logic [2:0] op_sel,
  input  logic [2:0] a_rows,
  input  logic [2:0] a_cols,
  input  logic [2:0] b_rows,
  input  logic [2:0] b_cols,
  output logic       calc_mat_conf,
  output logic       check_valid,
  output logic       check_invalid,
  output logic       error_timeout,
  output logic [3:0] countdown,
  output logic [2:0] res_rows,
  output logic [2:0] res_cols
);

  localparam logic [3:0]  ST_SELECT = 4'd8;
  localparam logic [3:0]  ST_CHECK  = 4'd9;
  localparam logic [3:0]  ST_ERROR  = 4'd12;
  localparam logic [26:0] PRESC_MAX = 27'(CLK_FREQ - 1);
  localparam logic [3:0]  CNT_LOAD  = 4'(ERR_SECONDS);

`ifdef CALC_CHECK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, EVAL, REPORT, WAIT_EXIT, COUNT} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [3:0]  prev_state_q, prev_state_d;
  logic [26:0] presc_q, presc_d;
  logic [3:0]  countdown_q, countdown_d;
  logic        calc_mat_conf_q, calc_mat_conf_d;
  logic        check_valid_q, check_valid_d;
  logic        check_invalid_q, check_invalid_d;
  logic        error_timeout_q, error_timeout_d;
  logic [2:0]  res_rows_q, res_rows_d;
  logic [2:0]  res_cols_q, res_cols_d;
  logic [2:0]  op_l_q, op_l_d;
  logic [2:0]  a_rows_l_q, a_rows_l_d;
  logic [2:0]  a_cols_l_q, a_cols_l_d;
  logic [2:0]  b_rows_l_q, b_rows_l_d;
  logic [2:0]  b_cols_l_q, b_cols_l_d;

  logic        entry_check;
  logic        entry_error;
  logic        a_ok;
  logic        b_ok;
  logic        eval_valid;
  logic [2:0]  eval_rows;
  logic [2:0]  eval_cols;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d >= 3'd1) && (d <= 3'd5);
  endfunction

  assign entry_check = (current_state == ST_CHECK) && (prev_state_q != ST_CHECK);
  assign entry_error = (current_state == ST_ERROR) && (prev_state_q != ST_ERROR);

  // Dimension rules evaluated on the operands captured at CHECK entry.
  always_comb begin
    a_ok       = dim_ok(a_rows_l_q) && dim_ok(a_cols_l_q);
    b_ok       = dim_ok(b_rows_l_q) && dim_ok(b_cols_l_q);
    eval_valid = 1'b0;
    eval_rows  = a_rows_l_q;
    eval_cols  = a_cols_l_q;
    case (op_l_q)
      3'b000: eval_valid = a_ok && b_ok && (a_rows_l_q == b_rows_l_q) && (a_cols_l_q == b_cols_l_q);
      3'b001: eval_valid = a_ok;
      3'b010: begin
        eval_valid = a_ok;
        eval_rows  = a_cols_l_q;
        eval_cols  = a_rows_l_q;
      end
      3'b011: begin
        eval_valid = a_ok && b_ok && (a_cols_l_q == b_rows_l_q);
        eval_cols  = b_cols_l_q;
      end
      default: eval_valid = 1'b0;
    endcase
  end

  always_comb begin
    fsm_d           = fsm_q;
    prev_state_d    = current_state;
    presc_d         = presc_q;
    countdown_d     = countdown_q;
    res_rows_d      = res_rows_q;
    res_cols_d      = res_cols_q;
    op_l_d          = op_l_q;
    a_rows_l_d      = a_rows_l_q;
    a_cols_l_d      = a_cols_l_q;
    b_rows_l_d      = b_rows_l_q;
    b_cols_l_d      = b_cols_l_q;
    check_valid_d   = 1'b0;
    check_invalid_d = 1'b0;
    error_timeout_d = 1'b0;
    calc_mat_conf_d = btn_c && ((current_state == ST_SELECT) || (RETRY_EN && (fsm_q == COUNT)));

    case (fsm_q)
      IDLE: begin
        if (entry_check) begin
          fsm_d      = EVAL;
          op_l_d     = op_sel;
          a_rows_l_d = a_rows;
          a_cols_l_d = a_cols;
          b_rows_l_d = b_rows;
          b_cols_l_d = b_cols;
        end else if (entry_error) begin
          fsm_d       = COUNT;
          countdown_d = CNT_LOAD;
          presc_d     = '0;
        end
      end
      EVAL: begin
        fsm_d           = REPORT;
        check_valid_d   = eval_valid;
        check_invalid_d = !eval_valid;
        if (eval_valid) begin
          res_rows_d = eval_rows;
          res_cols_d = eval_cols;
        end
      end
      REPORT: fsm_d = WAIT_EXIT;
      WAIT_EXIT: begin
        if (current_state != ST_CHECK) fsm_d = IDLE;
      end
      COUNT: begin
        // Leaving ERROR or a retry press both end the countdown silently.
        if ((current_state != ST_ERROR) || (RETRY_EN && btn_c)) begin
          fsm_d       = IDLE;
          countdown_d = '0;
        end else if (presc_q == PRESC_MAX) begin
          presc_d     = '0;
          countdown_d = countdown_q - 4'd1;
          if (countdown_q == 4'd1) begin
            error_timeout_d = 1'b1;
            fsm_d           = IDLE;
          end
        end else begin
          presc_d = presc_q + 27'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q           <= IDLE;
      prev_state_q    <= '0;
      presc_q         <= '0;
      countdown_q     <= '0;
      calc_mat_conf_q <= 1'b0;
      check_valid_q   <= 1'b0;
      check_invalid_q <= 1'b0;
      error_timeout_q <= 1'b0;
      res_rows_q      <= '0;
      res_cols_q      <= '0;
      op_l_q          <= '0;
      a_rows_l_q      <= '0;
      a_cols_l_q      <= '0;
      b_rows_l_q      <= '0;
      b_cols_l_q      <= '0;
    end else begin
      fsm_q           <= fsm_d;
      prev_state_q    <= prev_state_d;
      presc_q         <= presc_d;
      countdown_q     <= countdown_d;
      calc_mat_conf_q <= calc_mat_conf_d;
      check_valid_q   <= check_valid_d;
      check_invalid_q <= check_invalid_d;
      error_timeout_q <= error_timeout_d;
      res_rows_q      <= res_rows_d;
      res_cols_q      <= res_cols_d;
      op_l_q          <= op_l_d;
      a_rows_l_q      <= a_rows_l_d;
      a_cols_l_q      <= a_cols_l_d;
      b_rows_l_q      <= b_rows_l_d;
      b_cols_l_q      <= b_cols_l_d;
    end
  end

  assign calc_mat_conf = calc_mat_conf_q;
  assign check_valid   = check_valid_q;
  assign check_invalid = check_invalid_q;
  assign error_timeout = error_timeout_q;
  assign countdown     = countdown_q;
  assign res_rows      = res_rows_q;
  assign res_cols      = res_cols_q;

endmodule

// File: tb/tb_calc_check_ctrl.sv
// Testbench for calc_check_ctrl: directed scenarios with literal expectations plus
// randomized state/button/operand traffic compared every cycle against a behavioural model.
module tb_calc_check_ctrl;

  localparam int CLKF  = 4;
  localparam int ERRS  = 3;
  localparam int TOTAL = CLKF * ERRS;

`ifdef CALC_CHECK_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic       clk;
  logic       rst_n = 1'b1;
  logic [3:0] current_state;
  logic       btn_c;
  logic [2:0] op_sel;
  logic [2:0] a_rows, a_cols, b_rows, b_cols;
  logic       calc_mat_conf, check_valid, check_invalid, error_timeout;
  logic [3:0] countdown;
  logic [2:0] res_rows, res_cols;

  int n_vec = 0;
  int n_bad = 0;

  int exp_conf, exp_valid, exp_invalid, exp_timeout, exp_cd, exp_rr, exp_rc;

  calc_check_ctrl #(.CLK_FREQ(CLKF), .ERR_SECONDS(ERRS)) dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state), .btn_c(btn_c),
    .op_sel(op_sel), .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .calc_mat_conf(calc_mat_conf), .check_valid(check_valid), .check_invalid(check_invalid),
    .error_timeout(error_timeout), .countdown(countdown), .res_rows(res_rows), .res_cols(res_cols)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs are held for one clock cycle; returns just after the next rising edge.
  task automatic applyStimulus(input logic [3:0] cs, input logic b);
    current_state = cs;
    btn_c         = b;
    @(posedge clk);
    #1;
  endtask

  function automatic bit dims_ok(input int r, input int c);
    return (r >= 1) && (r <= 5) && (c >= 1) && (c <= 5);
  endfunction

  task automatic judge(input int op, input int ar, input int ac, input int br, input int bc,
                       output bit ok, output int r, output int c);
    ok = 1'b0;
    r  = ar;
    c  = ac;
    case (op)
      0: ok = dims_ok(ar, ac) && dims_ok(br, bc) && (ar == br) && (ac == bc);
      1: ok = dims_ok(ar, ac);
      2: begin ok = dims_ok(ar, ac); r = ac; c = ar; end
      3: begin ok = dims_ok(ar, ac) && dims_ok(br, bc) && (ac == br); c = bc; end
      default: ok = 1'b0;
    endcase
  endtask

  function automatic logic [3:0] pick_idle();
    logic [3:0] v;
    v = 4'($urandom_range(0, 15));
    if ((v == 4'd9) || (v == 4'd12)) v = 4'd8;
    return v;
  endfunction

  // Behavioural model: expectations for the cycle following each rising edge.
  initial begin
    int  m_prev, k, pend_r, pend_c, jr, jc;
    bit  err_on, pend_v, pend_ok, e9, e12, in_count, jok;
    m_prev = 0; k = 0; err_on = 0; pend_v = 0; pend_ok = 0; pend_r = 0; pend_c = 0;
    exp_conf = 0; exp_valid = 0; exp_invalid = 0; exp_timeout = 0; exp_cd = 0; exp_rr = 0; exp_rc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_prev = 0; k = 0; err_on = 0; pend_v = 0;
        exp_conf = 0; exp_valid = 0; exp_invalid = 0; exp_timeout = 0; exp_cd = 0; exp_rr = 0; exp_rc = 0;
      end else begin
        e9       = (current_state == 4'd9)  && (m_prev != 9);
        e12      = (current_state == 4'd12) && (m_prev != 12);
        in_count = err_on;
        exp_conf = (btn_c && ((current_state == 4'd8) || (RETRY && in_count))) ? 1 : 0;
        exp_valid   = (pend_v && pend_ok)  ? 1 : 0;
        exp_invalid = (pend_v && !pend_ok) ? 1 : 0;
        if (pend_v && pend_ok) begin
          exp_rr = pend_r;
          exp_rc = pend_c;
        end
        pend_v = e9;
        if (e9) begin
          judge(int'(op_sel), int'(a_rows), int'(a_cols), int'(b_rows), int'(b_cols), jok, jr, jc);
          pend_ok = jok; pend_r = jr; pend_c = jc;
        end
        exp_timeout = 0;
        if (in_count) begin
          if ((current_state != 4'd12) || (RETRY && btn_c)) begin
            err_on = 0;
            exp_cd = 0;
          end else begin
            k++;
            if (k == TOTAL) begin
              err_on = 0; exp_cd = 0; exp_timeout = 1;
            end else begin
              exp_cd = ERRS - k / CLKF;
            end
          end
        end else if (e12) begin
          err_on = 1; k = 0; exp_cd = ERRS;
        end
        m_prev = int'(current_state);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("calc_mat_conf", int'(calc_mat_conf), exp_conf);
      checkOutput("check_valid",   int'(check_valid),   exp_valid);
      checkOutput("check_invalid", int'(check_invalid), exp_invalid);
      checkOutput("error_timeout", int'(error_timeout), exp_timeout);
      checkOutput("countdown",     int'(countdown),     exp_cd);
      checkOutput("res_rows",      int'(res_rows),      exp_rr);
      checkOutput("res_cols",      int'(res_cols),      exp_rc);
    end
  end

  initial begin
    int cd_tab [13] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0};
    int seg_len;
    current_state = 4'd0; btn_c = 1'b0; op_sel = 3'd0;
    a_rows = 3'd0; a_cols = 3'd0; b_rows = 3'd0; b_cols = 3'd0;
    $display("[TB] start, CLK_FREQ=%0d ERR_SECONDS=%0d retry=%0d", CLKF, ERRS, RETRY);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_countdown", int'(countdown), 0);
    checkOutput("reset_res_rows", int'(res_rows), 0);
    rst_n = 1'b1;

    // Scenario 1: confirm pulse in SELECT_MAT
    repeat (10) applyStimulus(4'd8, 1'b0);
    applyStimulus(4'd8, 1'b1);
    checkOutput("s1_conf_next", int'(calc_mat_conf), 1);
    applyStimulus(4'd8, 1'b0);
    checkOutput("s1_conf_once", int'(calc_mat_conf), 0);
    repeat (4) applyStimulus(4'd0, 1'b0);

    // Scenario 2: matrix multiply 2x3 * 3x4
    op_sel = 3'd3; a_rows = 3'd2; a_cols = 3'd3; b_rows = 3'd3; b_cols = 3'd4;
    applyStimulus(4'd9, 1'b0);
    checkOutput("s2_valid_early", int'(check_valid), 0);
    applyStimulus(4'd9, 1'b0);
    checkOutput("s2_valid", int'(check_valid), 1);
    checkOutput("s2_invalid", int'(check_invalid), 0);
    checkOutput("s2_res_rows", int'(res_rows), 2);
    checkOutput("s2_res_cols", int'(res_cols), 4);
    repeat (6) begin
      applyStimulus(4'd9, 1'b0);
      checkOutput("s2_no_repeat", int'(check_valid | check_invalid), 0);
    end
    repeat (5) applyStimulus(4'd0, 1'b0);

    // Scenario 3: mismatched add, then illegal op
    op_sel = 3'd0; b_rows = 3'd3; b_cols = 3'd2;
    applyStimulus(4'd9, 1'b0);
    applyStimulus(4'd9, 1'b0);
    checkOutput("s3_add_invalid", int'(check_invalid), 1);
    checkOutput("s3_add_valid", int'(check_valid), 0);
    checkOutput("s3_hold_rows", int'(res_rows), 2);
    checkOutput("s3_hold_cols", int'(res_cols), 4);
    repeat (5) applyStimulus(4'd0, 1'b0);
    op_sel = 3'd7; b_rows = 3'd3; b_cols = 3'd4;
    applyStimulus(4'd9, 1'b0);
    applyStimulus(4'd9, 1'b0);
    checkOutput("s3_op7_invalid", int'(check_invalid), 1);
    checkOutput("s3_op7_hold_cols", int'(res_cols), 4);
    repeat (5) applyStimulus(4'd0, 1'b0);

    // Scenario 4: full countdown while holding ERROR
    applyStimulus(4'd12, 1'b0);
    for (int i = 0; i < 13; i++) begin
      checkOutput("s4_countdown", int'(countdown), cd_tab[i]);
      checkOutput("s4_timeout", int'(error_timeout), (i == 12) ? 1 : 0);
      applyStimulus(4'd12, 1'b0);
    end
    repeat (6) begin
      checkOutput("s4_after_timeout", int'(error_timeout), 0);
      checkOutput("s4_after_countdown", int'(countdown), 0);
      applyStimulus(4'd12, 1'b0);
    end
    repeat (5) applyStimulus(4'd0, 1'b0);

    // Scenario 5: btn_c while countdown shows 2
    applyStimulus(4'd12, 1'b0);
    repeat (4) applyStimulus(4'd12, 1'b0);
    checkOutput("s5_cd_before", int'(countdown), 2);
    applyStimulus(4'd12, 1'b1);
    checkOutput("s5_conf", int'(calc_mat_conf), RETRY ? 1 : 0);
    checkOutput("s5_cd_after", int'(countdown), RETRY ? 0 : 2);
    repeat (7) applyStimulus(4'd12, 1'b0);
    checkOutput("s5_timeout", int'(error_timeout), RETRY ? 0 : 1);
    checkOutput("s5_cd_end", int'(countdown), 0);
    repeat (5) applyStimulus(4'd0, 1'b0);

    // Scenario 6: reset in mid-countdown, release with ERROR still present
    applyStimulus(4'd12, 1'b0);
    repeat (5) applyStimulus(4'd12, 1'b0);
    checkOutput("s6_cd_pre", int'(countdown), 2);
    rst_n = 1'b0;
    #2;
    checkOutput("s6_async_cd", int'(countdown), 0);
    checkOutput("s6_async_conf", int'(calc_mat_conf), 0);
    repeat (3) applyStimulus(4'd12, 1'b0);
    checkOutput("s6_held_cd", int'(countdown), 0);
    rst_n = 1'b1;
    applyStimulus(4'd12, 1'b0);
    checkOutput("s6_fresh_cd", int'(countdown), 3);
    repeat (11) applyStimulus(4'd12, 1'b0);
    checkOutput("s6_cd_last", int'(countdown), 1);
    checkOutput("s6_no_early_timeout", int'(error_timeout), 0);
    applyStimulus(4'd12, 1'b0);
    checkOutput("s6_timeout", int'(error_timeout), 1);
    repeat (5) applyStimulus(4'd0, 1'b0);

    // Randomized segments separated by inactive gaps
    for (int s = 0; s < 300; s++) begin
      case ($urandom_range(0, 2))
        0: begin
          seg_len = $urandom_range(1, 6);
          repeat (seg_len) applyStimulus(4'd8, ($urandom_range(0, 2) == 0));
        end
        1: begin
          a_rows = 3'($urandom_range(0, 6)); a_cols = 3'($urandom_range(0, 6));
          b_rows = 3'($urandom_range(0, 6)); b_cols = 3'($urandom_range(0, 6));
          case ($urandom_range(0, 3))
            0: begin b_rows = a_rows; b_cols = a_cols; end
            1: b_rows = a_cols;
            default: ;
          endcase
          op_sel = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
          seg_len = $urandom_range(1, 10);
          repeat (seg_len) applyStimulus(4'd9, ($urandom_range(0, 3) == 0));
        end
        default: begin
          seg_len = $urandom_range(1, 30);
          repeat (seg_len) applyStimulus(4'd12, ($urandom_range(0, 7) == 0));
        end
      endcase
      seg_len = $urandom_range(4, 7);
      repeat (seg_len) applyStimulus(pick_idle(), ($urandom_range(0, 3) == 0));
    end

    repeat (3) applyStimulus(4'd0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
